// File: rtl/arbitro_compuerta.sv
// Shared parking barrier arbiter: grants the barrier to the entry or exit
// lane (round-robin when both are eligible), holds it open until the vehicle
// passes or the grant times out, then closes for one cycle. Tracks lot
// occupancy and refuses entry while the lot is full.
module arbitro_compuerta #(
   parameter int CAPACIDAD = 8,
   parameter int CW        = 4,
   parameter int T_MAX     = 16,
   parameter int TW        = 5
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Req_Entrada,
   input  logic          Req_Salida,
   input  logic          Paso,
   output logic          Gnt_Entrada,
   output logic          Gnt_Salida,
   output logic          Abrir,
   output logic [CW-1:0] Ocupacion,
   output logic          Lleno,
   output logic          Timeout_Err
);

   typedef enum logic [3:0] {
      LIBRE   = 4'b0001,
      GNT_ENT = 4'b0010,
      GNT_SAL = 4'b0100,
      CIERRE  = 4'b1000
   } estado_t;

   estado_t       estado_q, estado_d;
   logic          gnt_ent_q, gnt_ent_d;
   logic          gnt_sal_q, gnt_sal_d;
   logic          abrir_q, abrir_d;
   logic [CW-1:0] ocup_q, ocup_d;
   logic          tout_q, tout_d;
   // 1 when the entry lane was served last, so exit wins the next tie
   logic          ptr_q, ptr_d;
   logic [TW-1:0] cnt_q, cnt_d;

   logic lleno, elig_ent, elig_sal, es_ent;

   assign lleno    = (ocup_q == CW'(CAPACIDAD));
   assign elig_ent = Req_Entrada && !lleno;
   assign elig_sal = Req_Salida && (ocup_q != '0);
   assign es_ent   = (estado_q == GNT_ENT);

   // Next-state, next-output and occupancy/pointer/timer update
   always_comb begin
      estado_d  = estado_q;
      gnt_ent_d = 1'b0;
      gnt_sal_d = 1'b0;
      abrir_d   = 1'b0;
      ocup_d    = ocup_q;
      tout_d    = 1'b0;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      case (estado_q)
         LIBRE: begin
            if (elig_ent && (!elig_sal || !ptr_q)) begin
               estado_d  = GNT_ENT;
               gnt_ent_d = 1'b1;
               abrir_d   = 1'b1;
               cnt_d     = '0;
            end else if (elig_sal) begin
               estado_d  = GNT_SAL;
               gnt_sal_d = 1'b1;
               abrir_d   = 1'b1;
               cnt_d     = '0;
            end
         end
         GNT_ENT, GNT_SAL: begin
            if (Paso) begin
               // Paso beats a simultaneous timeout
               ocup_d   = es_ent ? ocup_q + 1'b1 : ocup_q - 1'b1;
               ptr_d    = es_ent;
               estado_d = CIERRE;
            end else if (cnt_q == TW'(T_MAX - 1)) begin
               tout_d   = 1'b1;
               ptr_d    = es_ent;
               estado_d = CIERRE;
            end else begin
               cnt_d     = cnt_q + 1'b1;
               gnt_ent_d = es_ent;
               gnt_sal_d = !es_ent;
               abrir_d   = 1'b1;
            end
         end
         CIERRE:  estado_d = LIBRE;
         default: estado_d = LIBRE;
      endcase
   end

   // State and registered outputs; reset abandons any grant in flight
   always_ff @(posedge Clk) begin
      if (Reset) begin
         estado_q  <= LIBRE;
         gnt_ent_q <= 1'b0;
         gnt_sal_q <= 1'b0;
         abrir_q   <= 1'b0;
         ocup_q    <= '0;
         tout_q    <= 1'b0;
         ptr_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         estado_q  <= estado_d;
         gnt_ent_q <= gnt_ent_d;
         gnt_sal_q <= gnt_sal_d;
         abrir_q   <= abrir_d;
         ocup_q    <= ocup_d;
         tout_q    <= tout_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   assign Gnt_Entrada = gnt_ent_q;
   assign Gnt_Salida  = gnt_sal_q;
   assign Abrir       = abrir_q;
   assign Ocupacion   = ocup_q;
   assign Lleno       = lleno;
   assign Timeout_Err = tout_q;

endmodule

// File: tb/tb_arbitro_compuerta.sv
// Directed bench for arbitro_compuerta: expected outputs are pushed to a
// scoreboard queue as each cycle's stimulus is driven and popped/compared
// one tick after the clock edge.
module tb_arbitro_compuerta;

   localparam int CAP = 8;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Req_Entrada = 1'b0, Req_Salida = 1'b0, Paso = 1'b0;
   logic       Gnt_Entrada, Gnt_Salida, Abrir, Lleno, Timeout_Err;
   logic [3:0] Ocupacion;

   int checks = 0;
   int failures = 0;
   int occ = 0;

   typedef struct {
      logic       ge, gs, ab, ll, to;
      logic [3:0] oc;
      string      tag;
   } exp_t;
   exp_t sb[$];

   arbitro_compuerta dut (
      .Clk(Clk), .Reset(Reset),
      .Req_Entrada(Req_Entrada), .Req_Salida(Req_Salida), .Paso(Paso),
      .Gnt_Entrada(Gnt_Entrada), .Gnt_Salida(Gnt_Salida), .Abrir(Abrir),
      .Ocupacion(Ocupacion), .Lleno(Lleno), .Timeout_Err(Timeout_Err)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input string f, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, f, obs, exp);
      end
   endtask

   // One clock: drive inputs, queue the expected post-edge outputs, compare
   task automatic cyc(input logic re, input logic rs, input logic pa,
                      input logic ge, input logic gs, input logic ab,
                      input int oc, input logic to, input string tag);
      exp_t e;
      Req_Entrada = re; Req_Salida = rs; Paso = pa;
      e.ge = ge; e.gs = gs; e.ab = ab; e.oc = 4'(oc);
      e.ll = (oc == CAP); e.to = to; e.tag = tag;
      sb.push_back(e);
      @(posedge Clk); #1;
      e = sb.pop_front();
      chk(e.tag, "gnt_ent", {3'b0, Gnt_Entrada}, {3'b0, e.ge});
      chk(e.tag, "gnt_sal", {3'b0, Gnt_Salida},  {3'b0, e.gs});
      chk(e.tag, "abrir",   {3'b0, Abrir},       {3'b0, e.ab});
      chk(e.tag, "ocup",    Ocupacion,           e.oc);
      chk(e.tag, "lleno",   {3'b0, Lleno},       {3'b0, e.ll});
      chk(e.tag, "tout",    {3'b0, Timeout_Err}, {3'b0, e.to});
   endtask

   // From LIBRE with requests (re,rs) held: expect a grant to lane `ent`
   // lasting n cycles, then Paso (pa_end=1) or a timeout, then CIERRE and
   // one LIBRE cycle with the barrier closed.
   task automatic serve(input logic re, input logic rs, input logic ent,
                        input int n, input logic pa_end, input string tag);
      for (int i = 0; i < n; i++)
         cyc(re, rs, 1'b0, ent, !ent, 1'b1, occ, 1'b0, tag);
      if (pa_end) occ = ent ? occ + 1 : occ - 1;
      cyc(re, rs, pa_end, 1'b0, 1'b0, 1'b0, occ, !pa_end, {tag, "_end"});
      cyc(re, rs, 1'b0,   1'b0, 1'b0, 1'b0, occ, 1'b0,    {tag, "_cierre"});
   endtask

   initial begin
      // Reset and idle
      Reset = 1'b1;
      cyc(0, 0, 0, 0, 0, 0, 0, 0, "reset");
      Reset = 1'b0;
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, "idle");

      // Single entry: grant held 4 cycles, Paso in the 4th
      serve(1, 0, 1, 4, 1, "ent1");
      // Paso outside a grant does nothing
      cyc(0, 0, 1, 0, 0, 0, occ, 0, "paso_libre");
      serve(1, 0, 1, 2, 1, "ent2");
      serve(1, 0, 1, 2, 1, "ent3");

      // Both requesting, entry served last -> exit, entry, exit, entry
      serve(1, 1, 0, 2, 1, "rr_sal1");
      serve(1, 1, 1, 2, 1, "rr_ent1");
      serve(1, 1, 0, 2, 1, "rr_sal2");
      serve(1, 1, 1, 2, 1, "rr_ent2");

      // Fill the lot, then entry requests are refused
      for (int k = 0; k < 5; k++) serve(1, 0, 1, 2, 1, "fill");
      for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0, 0, CAP, 0, "lleno_hold");

      // Exit frees a space; pending entry granted 2 cycles after exit ends
      serve(1, 1, 0, 2, 1, "libera_sal");
      serve(1, 0, 1, 2, 1, "pend_ent");
      serve(0, 1, 0, 2, 1, "sal_espacio");

      // Timeout: 16 grant cycles, pulse, no count change; then Paso on last
      serve(1, 0, 1, 16, 0, "timeout");
      serve(1, 0, 1, 16, 1, "paso_ultimo");

      // Reset mid exit grant, Paso in the same cycle must not count
      cyc(0, 1, 0, 0, 1, 1, occ, 0, "pre_rst_gnt");
      Reset = 1'b1;
      occ = 0;
      cyc(0, 1, 1, 0, 0, 0, 0, 0, "rst_mid_gnt");
      Reset = 1'b0;

      // Exit request with an empty lot is ignored
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, "sal_vacio");

      // Reset during an entry grant
      cyc(1, 0, 0, 1, 0, 1, 0, 0, "ent_gnt");
      cyc(0, 0, 0, 1, 0, 1, 0, 0, "ent_gnt2");
      Reset = 1'b1;
      cyc(0, 0, 1, 0, 0, 0, 0, 0, "rst_ent_gnt");
      Reset = 1'b0;
      cyc(0, 0, 0, 0, 0, 0, 0, 0, "post_rst");
      // After reset the lane pointer favours entry again
      serve(1, 0, 1, 2, 1, "post_rst_ent");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
